// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 8;
  localparam int OFFS_BITS  = $clog2(WORD_BYTES);

  // Returns {misaligned, out_of_range} for a byte address into a 2**aw word array.
  function automatic logic [1:0] addr_err(input logic [63:0] addr, input int aw);
    logic mis;
    logic oor;
    mis = (addr[OFFS_BITS-1:0] != '0);
    oor = ((addr >> (aw + OFFS_BITS)) != 64'd0);
    return {mis, oor};
  endfunction

endpackage

// File: rtl/dmem_resp_lat_ctr.sv
// Loadable 4-bit down-counter that paces the access latency.
module lat_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       is_one
);

  logic [3:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != 4'd0)) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  assign is_one = (cnt_reg == 4'd1);

endmodule

// File: rtl/dmem_resp.sv
// Memory end of the CPU data port: one outstanding load/store with
// valid/ready handshakes on both sides and a fixed access latency.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] Addr,
  input  logic        WrEn_d,
  input  logic [63:0] Db,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] DataInFromDMem,
  output logic        resp_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam bit FAST = (LATENCY == 1);

  state_t state_reg, state_next;

  logic          ready_reg;
  logic [63:0]   addr_reg, data_reg;
  logic          we_reg;
  logic          accept, do_access;
  logic          cnt_load, cnt_dec, cnt_is_one;
  logic [63:0]   acc_addr, acc_data;
  logic          acc_we;
  logic [1:0]    acc_err;
  logic          acc_fault;
  logic [AW-1:0] acc_idx;
  logic [63:0]   mem [DEPTH];
  logic [63:0]   rd_q;
  logic          load_ok_reg, err_reg;

  assign req_ready  = ready_reg && (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign accept     = req_valid && req_ready;

  // With single-cycle latency the access happens on the acceptance edge,
  // so it must use the live request inputs rather than the captured copy.
  assign acc_addr  = FAST ? Addr   : addr_reg;
  assign acc_data  = FAST ? Db     : data_reg;
  assign acc_we    = FAST ? WrEn_d : we_reg;
  assign acc_err   = addr_err(acc_addr, AW);
  assign acc_fault = |acc_err;
  assign acc_idx   = acc_addr[AW+OFFS_BITS-1:OFFS_BITS];

  lat_ctr u_lat_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (4'(LATENCY - 1)),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    do_access  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (FAST) begin
            do_access  = 1'b1;
            state_next = RESP;
          end else begin
            cnt_load   = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_is_one) begin
          do_access  = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ready_reg keeps req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b0;
      load_ok_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= 1'b1;
      if (do_access) begin
        err_reg     <= acc_fault;
        load_ok_reg <= !acc_fault && !acc_we;
      end else if (resp_valid && resp_ready) begin
        err_reg     <= 1'b0;
        load_ok_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_reg <= Addr;
      data_reg <= Db;
      we_reg   <= WrEn_d;
    end
  end

  // Read-before-write array port; rd_q only moves on an access so it stays
  // stable for the whole RESP phase.
  always_ff @(posedge clk) begin
    if (do_access && !acc_fault) begin
      if (acc_we) mem[acc_idx] <= acc_data;
      else        rd_q         <= mem[acc_idx];
    end
  end

  assign DataInFromDMem = load_ok_reg ? rd_q : 64'd0;
  assign resp_err       = err_reg;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: driver pushes expected responses, a
// negedge monitor pops and compares; extra instances cover latency 1 and 15.
module tb_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] Addr = '0;
  logic        WrEn_d = 1'b0;
  logic [63:0] Db = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] DataInFromDMem;
  logic        resp_err;

  logic        x_rqv   [2];
  logic        x_rqr   [2];
  logic [63:0] x_addr  [2];
  logic        x_we    [2];
  logic [63:0] x_db    [2];
  logic        x_rsv   [2];
  logic [63:0] x_dout  [2];
  logic        x_err   [2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  exp_t cur_exp;
  bit   in_resp = 0;
  bit   rand_rr = 0;
  int   bp_req = 0;
  int   stall_left = 0;
  logic [63:0] model_mem [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .Addr           (Addr),
    .WrEn_d         (WrEn_d),
    .Db             (Db),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .DataInFromDMem (DataInFromDMem),
    .resp_err       (resp_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_side
      dmem_resp #(.DEPTH(DEPTH), .LATENCY(gi == 0 ? 1 : 15)) u_side (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (x_rqv[gi]),
        .req_ready      (x_rqr[gi]),
        .Addr           (x_addr[gi]),
        .WrEn_d         (x_we[gi]),
        .Db             (x_db[gi]),
        .resp_valid     (x_rsv[gi]),
        .resp_ready     (1'b1),
        .DataInFromDMem (x_dout[gi]),
        .resp_err       (x_err[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one request; when track is set, the reference model predicts the response.
  task automatic issue(input logic [63:0] a, input logic we, input logic [63:0] d, input bit track);
    int t;
    int n;
    exp_t e;
    bit bad;
    @(negedge clk);
    req_valid = 1'b1; Addr = a; WrEn_d = we; Db = d;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: addr 0x%0h never accepted", a);
      req_valid = 1'b0;
      return;
    end
    n = cyc;
    if (track) begin
      bad = (a % 8 != 0) || (a >= 64'(DEPTH) * 8);
      e.err = bad;
      e.due = n + LAT;
      e.data = 64'd0;
      if (!bad) begin
        if (we) model_mem[int'(a / 8)] = d;
        else if (model_mem.exists(int'(a / 8))) e.data = model_mem[int'(a / 8)];
      end
      exp_q.push_back(e);
    end
    $display("req  cyc=%0d %s addr=0x%0h data=0x%0h track=%0d", n, we ? "ST" : "LD", a, d, track);
    @(posedge clk);
    #1;
    req_valid = 1'b0; Addr = 'x; WrEn_d = 1'bx; Db = 'x;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || in_resp) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
    end
  endtask

  task automatic side_run(input int k, input int lat);
    int t;
    int n;
    logic [63:0] d;
    d = rnd64();
    for (int op = 0; op < 2; op++) begin
      @(negedge clk);
      x_rqv[k] = 1'b1; x_addr[k] = 64'h18; x_we[k] = (op == 0); x_db[k] = d;
      t = 0;
      while (!x_rqr[k] && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("lat%0d_accept", lat), 64'(x_rqr[k]), 64'd1);
      n = cyc;
      @(posedge clk);
      #1;
      x_rqv[k] = 1'b0;
      @(negedge clk);
      t = 0;
      while (!x_rsv[k] && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("lat%0d_latency", lat), 64'(cyc - n), 64'(lat));
      chk($sformatf("lat%0d_data", lat), x_dout[k], (op == 0) ? 64'd0 : d);
      chk($sformatf("lat%0d_err", lat), 64'(x_err[k]), 64'd0);
      $display("side lat=%0d %s latency=%0d data=0x%0h", lat, op == 0 ? "ST" : "LD", cyc - n, x_dout[k]);
    end
  endtask

  // Monitor: first sighting of a response pops the scoreboard; later cycles check hold.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (!in_resp) begin
        in_resp = 1;
        stall_left = bp_req;
        bp_req = 0;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_resp: data 0x%0h err %0d with nothing outstanding", DataInFromDMem, resp_err);
          cur_exp.data = 64'd0; cur_exp.err = 1'b0; cur_exp.due = cyc;
        end else begin
          cur_exp = exp_q.pop_front();
          chk("latency", 64'(cyc), 64'(cur_exp.due));
        end
        $display("resp cyc=%0d data=0x%0h err=%0d", cyc, DataInFromDMem, resp_err);
      end
      chk("resp_data", DataInFromDMem, cur_exp.data);
      chk("resp_err", 64'(resp_err), 64'(cur_exp.err));
      chk("req_ready_in_resp", 64'(req_ready), 64'd0);
      if (stall_left > 0) begin
        resp_ready = 1'b0;
        stall_left--;
      end else begin
        resp_ready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (resp_ready) in_resp = 0;
    end else begin
      resp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    logic [63:0] d;
    logic [63:0] a;
    int kind;
    for (int k = 0; k < 2; k++) begin
      x_rqv[k] = 1'b0; x_addr[k] = '0; x_we[k] = 1'b0; x_db[k] = '0;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_data", DataInFromDMem, 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'(req_ready), 64'd1);

    // Seed words used later, then the basic store/load pair
    issue(64'h0, 1'b1, rnd64(), 1);
    issue(64'h40, 1'b1, 64'h0BAD_F00D_0000_0040, 1);
    issue(64'h10, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1);
    issue(64'h10, 1'b0, 64'd0, 1);

    // Faults: misaligned load, out-of-range store, alias word unchanged
    issue(64'h13, 1'b0, 64'd0, 1);
    issue(64'h2000, 1'b1, rnd64(), 1);
    issue(64'h0, 1'b0, 64'd0, 1);

    // Backpressure with a pending request held behind it
    drain();
    bp_req = 5;
    issue(64'h10, 1'b0, 64'd0, 1);
    issue(64'h40, 1'b0, 64'd0, 1);
    drain();

    // Asynchronous reset during WAIT drops the store
    issue(64'h40, 1'b1, 64'h1234, 0);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_data", DataInFromDMem, 64'd0);
    chk("midrst_err", 64'(resp_err), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("midrst_held_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    issue(64'h40, 1'b0, 64'd0, 1);

    // Alternating store/load stream with random response backpressure
    rand_rr = 1;
    for (int i = 0; i < 8; i++) begin
      d = rnd64();
      issue(64'(i * 8), 1'b1, d, 1);
      issue(64'(i * 8), 1'b0, 64'd0, 1);
    end

    // Random mix over the seeded words, including faulting addresses
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = 64'($urandom_range(0, 7) * 8 + $urandom_range(1, 7));
      else if (kind == 1) a = rnd64() | 64'h2000;
      else                a = 64'($urandom_range(0, 7) * 8);
      issue(a, 1'($urandom_range(0, 1)), rnd64(), 1);
    end
    drain();
    rand_rr = 0;

    side_run(0, 1);
    side_run(1, 15);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
